// File: rtl/tick_timer_ctrl.sv
// Programmable tick/square-wave generator: one tick every half_q cycles while running, first tick H edges after start.
// Config is handshaked and only accepted while idle (cfg_ready low in RUN); tick/done/clko/busy are registered.
module tick_timer_ctrl #(
   parameter int WIDTH        = 25,
   parameter int DEFAULT_HALF = 25000000
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [WIDTH-1:0] cfg_half,
   input  logic             cfg_oneshot,
   input  logic             start,
   input  logic             stop,
   output logic             busy,
   output logic             tick,
   output logic             done,
   output logic             clko
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] half_q, half_d;
   logic             oneshot_q, oneshot_d;
   logic             tick_q, tick_d;
   logic             done_q, done_d;
   logic             clko_q, clko_d;
   logic             busy_q, busy_d;
   logic             cfg_accept;
   logic             terminal;

   assign cfg_ready  = (state_q == IDLE);
   assign cfg_accept = cfg_valid && cfg_ready;
   assign terminal   = (cnt_q == half_q - WIDTH'(1));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         half_q    <= WIDTH'(DEFAULT_HALF);
         oneshot_q <= 1'b0;
         tick_q    <= 1'b0;
         done_q    <= 1'b0;
         clko_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         half_q    <= half_d;
         oneshot_q <= oneshot_d;
         tick_q    <= tick_d;
         done_q    <= done_d;
         clko_q    <= clko_d;
         busy_q    <= busy_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      half_d    = half_q;
      oneshot_d = oneshot_q;
      tick_d    = 1'b0;
      done_d    = 1'b0;
      clko_d    = clko_q;
      busy_d    = busy_q;
      case (state_q)
         IDLE: begin
            // A config accepted alongside start takes effect for that same run.
            if (cfg_accept) begin
               half_d    = (cfg_half == '0) ? WIDTH'(1) : cfg_half;
               oneshot_d = cfg_oneshot;
            end
            if (start && !stop) begin
               state_d = RUN;
               cnt_d   = '0;
               clko_d  = 1'b0;
               busy_d  = 1'b1;
            end
         end
         RUN: begin
            // Stop beats a coincident terminal count: no tick, no toggle.
            if (stop) begin
               state_d = IDLE;
               cnt_d   = '0;
               clko_d  = 1'b0;
               busy_d  = 1'b0;
            end else if (terminal) begin
               cnt_d  = '0;
               tick_d = 1'b1;
               clko_d = ~clko_q;
               if (oneshot_q) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
                  busy_d  = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + WIDTH'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy = busy_q;
   assign tick = tick_q;
   assign done = done_q;
   assign clko = clko_q;

endmodule

// File: tb/tb_tick_timer_ctrl.sv
// Directed bench for tick_timer_ctrl built with a short default half-period of 5.
module tb_tick_timer_ctrl;

   localparam int WIDTH = 25;
   localparam int DEF_H = 5;

   logic             clk = 1'b0;
   logic             rstn = 1'b0;
   logic             cfg_valid = 1'b0;
   logic             cfg_ready;
   logic [WIDTH-1:0] cfg_half = '0;
   logic             cfg_oneshot = 1'b0;
   logic             start = 1'b0;
   logic             stop = 1'b0;
   logic             busy, tick, done, clko;

   int n_chk  = 0;
   int n_fail = 0;

   tick_timer_ctrl #(.WIDTH(WIDTH), .DEFAULT_HALF(DEF_H)) dut (
      .clk(clk), .rstn(rstn),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_half(cfg_half), .cfg_oneshot(cfg_oneshot),
      .start(start), .stop(stop),
      .busy(busy), .tick(tick), .done(done), .clko(clko)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      // Reset state
      step(); step();
      chk("rst_busy", 32'(busy), 0);
      chk("rst_tick", 32'(tick), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_clko", 32'(clko), 0);
      chk("rst_cfg_ready", 32'(cfg_ready), 1);

      // 1: default half-period, first tick at edge 5
      rstn = 1'b1;
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      chk("t1_busy", 32'(busy), 1);
      chk("t1_cfg_ready_run", 32'(cfg_ready), 0);
      for (int i = 1; i <= DEF_H; i++) begin
         step();
         chk("t1_tick", 32'(tick), (i == DEF_H) ? 1 : 0);
      end
      chk("t1_clko", 32'(clko), 1);
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk("t1_stop_busy", 32'(busy), 0);
      chk("t1_stop_clko", 32'(clko), 0);
      chk("t1_stop_ready", 32'(cfg_ready), 1);

      // 2: half=4 continuous, config accepted together with start
      cfg_valid = 1'b1; cfg_half = 4; cfg_oneshot = 1'b0; start = 1'b1;
      step();
      cfg_valid = 1'b0; start = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         step();
         chk("t2_tick", 32'(tick), (i % 4 == 0) ? 1 : 0);
         chk("t2_clko", 32'(clko), (i / 4) % 2);
      end
      stop = 1'b1;
      step();
      stop = 1'b0;

      // 3: half=3 one-shot
      cfg_valid = 1'b1; cfg_half = 3; cfg_oneshot = 1'b1;
      step();
      cfg_valid = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         step();
         chk("t3_tick", 32'(tick), (i == 3) ? 1 : 0);
         chk("t3_done", 32'(done), (i == 3) ? 1 : 0);
      end
      chk("t3_busy", 32'(busy), 0);
      chk("t3_ready", 32'(cfg_ready), 1);
      chk("t3_clko", 32'(clko), 1);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t3_no_tick", 32'(tick), 0);
         chk("t3_no_done", 32'(done), 0);
         chk("t3_clko_hold", 32'(clko), 1);
      end

      // 4: config offers ignored while running, accepted after stop
      cfg_valid = 1'b1; cfg_half = 4; cfg_oneshot = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      cfg_half = 9;
      #1;
      chk("t4_ready_run", 32'(cfg_ready), 0);
      for (int i = 1; i <= 8; i++) begin
         step();
         chk("t4_tick_period", 32'(tick), (i % 4 == 0) ? 1 : 0);
      end
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk("t4_ready_idle", 32'(cfg_ready), 1);
      step();
      cfg_valid = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 1; i <= 9; i++) begin
         step();
         chk("t4_tick_h9", 32'(tick), (i == 9) ? 1 : 0);
      end
      stop = 1'b1;
      step();
      stop = 1'b0;

      // 5: stop on the terminal cycle suppresses the tick
      cfg_valid = 1'b1; cfg_half = 4; cfg_oneshot = 1'b0; start = 1'b1;
      step();
      cfg_valid = 1'b0; start = 1'b0;
      for (int i = 1; i <= 7; i++) step();
      chk("t5_clko_before", 32'(clko), 1);
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk("t5_stop_tick", 32'(tick), 0);
      chk("t5_stop_clko", 32'(clko), 0);
      chk("t5_stop_busy", 32'(busy), 0);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("t5_idle_tick", 32'(tick), 0);
      end
      // half=0 behaves as half=1: tick every cycle, clko at clk/2
      cfg_valid = 1'b1; cfg_half = 0; start = 1'b1;
      step();
      cfg_valid = 1'b0; start = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         step();
         chk("t5_h1_tick", 32'(tick), 1);
         chk("t5_h1_clko", 32'(clko), i % 2);
      end
      stop = 1'b1;
      step();
      stop = 1'b0;

      // 6: asynchronous reset mid-run restores default half-period
      cfg_valid = 1'b1; cfg_half = 3; start = 1'b1;
      step();
      cfg_valid = 1'b0; start = 1'b0;
      for (int i = 1; i <= 5; i++) step();
      chk("t6_busy_before", 32'(busy), 1);
      chk("t6_clko_before", 32'(clko), 1);
      rstn = 1'b0;
      #1;
      chk("t6_busy", 32'(busy), 0);
      chk("t6_clko", 32'(clko), 0);
      chk("t6_tick", 32'(tick), 0);
      chk("t6_done", 32'(done), 0);
      chk("t6_ready", 32'(cfg_ready), 1);
      step(); step();
      chk("t6_hold_tick", 32'(tick), 0);
      rstn = 1'b1;
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 1; i <= DEF_H; i++) begin
         step();
         chk("t6_default_tick", 32'(tick), (i == DEF_H) ? 1 : 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
